// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment lookup for the seven-segment scan driver.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    // gfedcba, active-high, indexed by nibble value
    localparam seg7_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 0-F nibble to seven-segment pattern (active-high gfedcba).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with double-buffered loads,
// leading-zero blanking and per-slot anode dead time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    ld,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    upd_pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic          SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic          AN_INV    = (AN_ACTIVE_LOW != 0);

    logic [CW-1:0]                 div_cnt;
    logic [IW-1:0]                 digit_idx;
    logic [NUM_DIGITS-1:0][3:0]    act_nib, pend_nib;
    logic [NUM_DIGITS-1:0]         act_dp, pend_dp, act_blank, pend_blank;

    logic slot_wrap, frame_end;
    assign slot_wrap = (div_cnt == DIV_LAST);
    assign frame_end = slot_wrap && (digit_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (slot_wrap) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // A load landing on the frame boundary bypasses the pending buffer entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_nib     <= '0;
            act_dp      <= '0;
            act_blank   <= '0;
            pend_nib    <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            upd_pending <= 1'b0;
        end else if (ld && frame_end) begin
            act_nib     <= din;
            act_dp      <= dp_in;
            act_blank   <= blank_in;
            upd_pending <= 1'b0;
        end else if (ld) begin
            pend_nib    <= din;
            pend_dp     <= dp_in;
            pend_blank  <= blank_in;
            upd_pending <= 1'b1;
        end else if (frame_end && upd_pending) begin
            act_nib     <= pend_nib;
            act_dp      <= pend_dp;
            act_blank   <= pend_blank;
            upd_pending <= 1'b0;
        end
    end

    // zero_above[i]: every nibble from the top digit down to i is zero
    logic [NUM_DIGITS-1:0] zero_above;
    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (act_nib[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (act_nib[i] == 4'h0);
        end
    end

    seg7_t cur_seg;
    seg7_hex_decoder u_dec (
        .nibble (act_nib[digit_idx]),
        .seg    (cur_seg)
    );

    logic                  blanked, lit, dp_next;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        blanked  = act_blank[digit_idx] ||
                   (lz_en && (digit_idx != '0) && zero_above[digit_idx]);
        lit      = en && !blanked && (div_cnt >= BLANK_END);
        seg_next = blanked ? 7'h00 : cur_seg;
        dp_next  = !blanked && act_dp[digit_idx];
        an_next  = lit ? (NUM_DIGITS'(1) << digit_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= {7{SEG_INV}};
            dp         <= SEG_INV;
            an         <= {NUM_DIGITS{AN_INV}};
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next ^ {7{SEG_INV}};
            dp         <= dp_next ^ SEG_INV;
            an         <= an_next ^ {NUM_DIGITS{AN_INV}};
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver against a slot-arithmetic reference model.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        ld = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;
    logic        upd_pending;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .din(din), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
        .frame_tick(frame_tick), .upd_pending(upd_pending)
    );

    // Reference model: m_k is the count of clock edges since reset release,
    // so the counter state at that edge is slot (m_k/RD)%ND, position m_k%RD.
    int          m_k;
    logic [15:0] m_din, p_din;
    logic [3:0]  m_dp, p_dp, m_bl, p_bl;
    logic        m_pf;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_ft;

    function automatic int digit_of(input int k);
        return (k / RD) % ND;
    endfunction

    function automatic logic is_blank(input int k, input logic [15:0] a,
                                      input logic [3:0] bl, input logic lz);
        int d = digit_of(k);
        return bl[d] || (lz && d != 0 && ((a >> (4 * d)) == 16'h0));
    endfunction

    function automatic logic [6:0] f_seg(input int k, input logic [15:0] a,
                                         input logic [3:0] bl, input logic lz);
        int d = digit_of(k);
        logic [3:0] nib = a[4*d +: 4];
        return is_blank(k, a, bl, lz) ? 7'h00 : SEG_TBL[nib];
    endfunction

    function automatic logic [3:0] f_an(input int k, input logic [15:0] a,
                                        input logic [3:0] bl, input logic lz,
                                        input logic e);
        int d = digit_of(k);
        logic [3:0] one = 4'b0001 << d;
        return (e && !is_blank(k, a, bl, lz) && (k % RD) >= BC) ? ~one : 4'hF;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k <= 0;
            m_din <= '0; m_dp <= '0; m_bl <= '0;
            p_din <= '0; p_dp <= '0; p_bl <= '0;
            m_pf <= 1'b0;
            exp_seg <= 7'h00; exp_dp <= 1'b0; exp_an <= 4'hF; exp_ft <= 1'b0;
        end else begin
            exp_seg <= f_seg(m_k, m_din, m_bl, lz_en);
            exp_dp  <= !is_blank(m_k, m_din, m_bl, lz_en) && m_dp[digit_of(m_k)];
            exp_an  <= f_an(m_k, m_din, m_bl, lz_en, en);
            exp_ft  <= (m_k % FRAME) == FRAME - 1;
            if (ld && (m_k % FRAME) == FRAME - 1) begin
                m_din <= din; m_dp <= dp_in; m_bl <= blank_in; m_pf <= 1'b0;
            end else if (ld) begin
                p_din <= din; p_dp <= dp_in; p_bl <= blank_in; m_pf <= 1'b1;
            end else if ((m_k % FRAME) == FRAME - 1) begin
                if (m_pf) begin
                    m_din <= p_din; m_dp <= p_dp; m_bl <= p_bl;
                end
                m_pf <= 1'b0;
            end
            m_k <= m_k + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ft = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle_check();
        cyc++;
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("an", 32'(an), 32'(exp_an));
        chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
        chk("upd_pending", 32'(upd_pending), 32'(m_pf));
        if (rst) begin
            last_ft = -1;
        end else if (frame_tick) begin
            if (last_ft >= 0) chk("frame_period", 32'(cyc - last_ft), 32'(FRAME));
            last_ft = cyc;
        end
    endtask

    // Returns at the negedge whose outputs reflect slot d, position pos.
    task automatic wait_slot(input int d, input int pos);
        logic found = 1'b0;
        for (int g = 0; g < 4 * FRAME && !found; g++) begin
            @(negedge clk);
            if (m_k > 0 && ((m_k - 1) % FRAME) == d * RD + pos) found = 1'b1;
        end
        if (!found) begin
            n_chk++; n_fail++;
            $display("FAIL wait_slot timeout: slot %0d pos %0d not reached", d, pos);
        end
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int g = 0; g < 4 * FRAME && !done; g++) begin
            @(negedge clk);
            if (!upd_pending) done = 1'b1;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle timeout: upd_pending stuck at 1");
        end
    endtask

    // Called at a negedge; the load is taken at the following posedge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dv, input logic [3:0] bv);
        ld = 1'b1; din = v; dp_in = dv; blank_in = bv;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run();
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_upd", 32'(upd_pending), 32'h0);
        rst = 1'b0;
        wait_slot(0, 0); chk("dead0_an", 32'(an), 32'hF);
        wait_slot(0, 1); chk("dead1_an", 32'(an), 32'hF);
        wait_slot(0, 2); chk("d0_zero_an", 32'(an), 32'hE);
        chk("d0_zero_seg", 32'(seg), 32'h3F);

        wait_slot(1, 0);
        do_load(16'h1234, 4'b0010, 4'b0000);
        chk("load_pending", 32'(upd_pending), 32'h1);
        wait_idle();
        wait_slot(0, 3); chk("s0_seg", 32'(seg), 32'h66); chk("s0_an", 32'(an), 32'hE);
        wait_slot(1, 3); chk("s1_seg", 32'(seg), 32'h4F); chk("s1_an", 32'(an), 32'hD);
        chk("s1_dp", 32'(dp), 32'h1);
        wait_slot(2, 3); chk("s2_seg", 32'(seg), 32'h5B); chk("s2_an", 32'(an), 32'hB);
        chk("s2_dp", 32'(dp), 32'h0);
        wait_slot(3, 3); chk("s3_seg", 32'(seg), 32'h06); chk("s3_an", 32'(an), 32'h7);

        for (int v = 0; v < 16; v++) begin
            wait_slot(1, 0);
            do_load(16'(v * 16'h1111), 4'b0000, 4'b0000);
            wait_idle();
            wait_slot(2, 4);
            chk($sformatf("sweep_%0h", v), 32'(seg), 32'(SEG_TBL[v]));
        end

        lz_en = 1'b1;
        wait_slot(1, 0);
        do_load(16'h0040, 4'b0000, 4'b0000);
        wait_idle();
        wait_slot(0, 3); chk("lz_d0_seg", 32'(seg), 32'h3F); chk("lz_d0_an", 32'(an), 32'hE);
        wait_slot(1, 3); chk("lz_d1_seg", 32'(seg), 32'h66); chk("lz_d1_an", 32'(an), 32'hD);
        wait_slot(2, 3); chk("lz_d2_seg", 32'(seg), 32'h00); chk("lz_d2_an", 32'(an), 32'hF);
        wait_slot(3, 3); chk("lz_d3_seg", 32'(seg), 32'h00); chk("lz_d3_an", 32'(an), 32'hF);
        wait_slot(1, 0);
        do_load(16'h0000, 4'b0000, 4'b0000);
        wait_idle();
        wait_slot(0, 3); chk("lz0_d0_seg", 32'(seg), 32'h3F); chk("lz0_d0_an", 32'(an), 32'hE);
        wait_slot(1, 3); chk("lz0_d1_an", 32'(an), 32'hF);
        lz_en = 1'b0;

        wait_slot(1, 0);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        wait_slot(2, 0);
        do_load(16'h5555, 4'b0000, 4'b0000);
        chk("tear_pending", 32'(upd_pending), 32'h1);
        wait_slot(3, 3); chk("tear_old_seg", 32'(seg), 32'h3F);
        wait_slot(0, 3); chk("tear_new0_seg", 32'(seg), 32'h6D);
        wait_slot(2, 3); chk("tear_new2_seg", 32'(seg), 32'h6D);

        wait_slot(3, 6);
        do_load(16'h7777, 4'b0000, 4'b0000);
        chk("bnd_pending", 32'(upd_pending), 32'h0);
        for (int d = 0; d < ND; d++) begin
            wait_slot(d, 3);
            chk($sformatf("bnd_d%0d_seg", d), 32'(seg), 32'h07);
        end

        wait_slot(1, 3);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_an", 32'(an), 32'hF);
        repeat (40) @(negedge clk);
        en = 1'b1;

        wait_slot(1, 0);
        do_load(16'h89AB, 4'b1111, 4'b0000);
        wait_slot(2, 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h00);
        chk("arst_dp", 32'(dp), 32'h0);
        chk("arst_upd", 32'(upd_pending), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_slot(0, 3); chk("post_rst_d0_seg", 32'(seg), 32'h3F);
        wait_slot(3, 3); chk("post_rst_d3_seg", 32'(seg), 32'h3F);
        chk("post_rst_d3_dp", 32'(dp), 32'h0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ld = ($urandom_range(0, 11) == 0);
            din = 16'($urandom) >> $urandom_range(0, 16);
            dp_in = 4'($urandom);
            blank_in = 4'($urandom) & 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            en = ($urandom_range(0, 19) != 0);
        end
        @(negedge clk);
        ld = 1'b0;
        en = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                cycle_check();
            end
            run();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed seven-segment display driver. It replaces the per-segment combinational decoders with a full 0-F hex decoder, a refresh scan counter, and a double-buffered load interface so that display updates never tear mid-frame. It sits between the control logic, which supplies packed hex nibbles, and the board's shared segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 2, dead-time cycles at the start of each slot with all anodes off (anti-ghosting)
SEG_ACTIVE_LOW, 0, 1 means seg and dp pins are driven low-true
AN_ACTIVE_LOW, 1, 1 means anode pins are driven low-true

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  display enable; when 0, all anodes are inactive but scanning continues
ld  in  1  single-cycle load strobe for din/dp_in/blank_in
din  in  4*NUM_DIGITS  hex nibbles; digit 0 is in [3:0]
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  per-digit forced blank
lz_en  in  1  leading-zero blanking enable (sampled live)
seg  out  7  segments, bit0=a through bit6=g
dp  out  1  decimal point of the current digit
an  out  NUM_DIGITS  digit anodes, one-hot when active
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0
upd_pending  out  1  loaded data is waiting for the next frame boundary

Behaviour:
- Reset, asynchronous: div_cnt=0, digit_idx=0, active and pending registers cleared, upd_pending=0, frame_tick=0. seg and dp are driven inactive, meaning all zeros, or all ones if SEG_ACTIVE_LOW. an is driven inactive.
- Counters:
  - div_cnt counts 0..REFRESH_DIV-1 and then wraps.
  - On each wrap, digit_idx increments; NUM_DIGITS-1 wraps to 0.
  - A frame boundary is the cycle where div_cnt==REFRESH_DIV-1 and digit_idx==NUM_DIGITS-1.
- Load / double-buffer:
  - ld copies din/dp_in/blank_in into the pending registers and sets upd_pending.
  - If ld repeats while upd_pending=1, the last load wins.
  - At a frame boundary with upd_pending=1, pending is copied to active and upd_pending clears.
  - If ld coincides with a frame boundary, the ld data goes straight to active and upd_pending stays 0.
- frame_tick is registered and is high during the first cycle of digit 0's slot.
- Decode table for the active nibble, in gfedcba, active-high:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Digit blanking: a digit is blanked if blank_in[i] is set in active, or if it is a leading zero.
  - Leading zero: lz_en=1 and every active nibble from NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never leading-zero blanked.
  - A blanked digit drives its anode inactive and seg/dp inactive.
- Dead time: while div_cnt<BLANK_CYCLES, all anodes are inactive. seg/dp already present the new digit's value.
- Outputs are registered, one cycle of latency from the counter state. Polarity inversion is applied at the output register.
- en=0: an inactive the next cycle; counters, frame_tick and buffering are unaffected.
- Reset mid-frame: outputs go inactive immediately, without a clock edge. After reset release, the first frame starts at digit 0 with active data all zero.

Decomposition:
- Shared package seg7_pkg:
  - SEG_HEX localparam table, 16 x 7 bits
  - function hex_to_seg(nibble)
  - typedef seg7_t (7-bit)
- One natural sub-module: seg7_hex_decoder, combinational nibble -> seg7_t. It is instantiated once on the muxed active nibble.

Test Plan:
Bench parameters throughout: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1.
1. Reset, hold rst=1 for 3 cycles, then release -> seg=7'h00, dp=0, an=4'hF, upd_pending=0. After release, an stays 4'hF for slot cycles 0-1.
2. Load and scan: ld with din=16'h1234, dp_in=4'b0010 -> upd_pending=1 until the frame boundary. Next frame:
   - digit0: seg=66, an=1110
   - digit1: seg=4F, dp=1, an=1101
   - digit2: seg=5B, an=1011
   - digit3: seg=06, an=0111
   - frame_tick is seen once per 32 cycles.
3. Decode sweep: load each of din=16'h0000..16'hFFFF in steps of 16'h1111 -> the seg value matches the table for every nibble value 0-F.
4. Leading-zero blanking: lz_en=1, din=16'h0040 -> digits 3 and 2 show an=1111 and seg=00; digit1 shows seg=66; digit0 shows seg=3F. With din=16'h0000, only digit0 lights, seg=3F.
5. No tearing and ld collisions:
   - ld 16'hAAAA in slot 1, then ld 16'h5555 in slot 2 -> the current frame still shows the old data; the next frame shows 5 in all digits (seg=6D).
   - ld 16'h7777 exactly on a frame boundary -> the next frame shows seg=07 with upd_pending=0 throughout.
6. Async reset and enable:
   - Assert rst mid-slot between clock edges -> an=4'hF and seg=00 before the next edge.
   - Separately, en=0 during digit1 -> an=4'hF the next cycle while frame_tick keeps its 32-cycle period.
